id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of the PC and immediate datapath (legal values 32 or 64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of buffered decoded-instruction entries (legal values 1 to 4).
REQ-003 SHALL have port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, width 1, an asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, width 1, meaning the upstream instr/pc are valid.
REQ-006 SHALL have port in_ready, output, width 1, meaning the stage accepts input this cycle.
REQ-007 SHALL have port instr, input, width 32, the raw RV32 instruction word.
REQ-008 SHALL have port PC_n, input, width XLEN, the PC of instr.
REQ-009 SHALL have port flush, input, width 1, which discards all buffered and incoming entries.
REQ-010 SHALL have port out_valid, output, width 1, meaning the head entry is valid.
REQ-011 SHALL have port out_ready, input, width 1, meaning the downstream EX stage consumes the head entry.
REQ-012 SHALL have ports opcode_n (7), funct3_n (3), funct7_n (7), rs1_n (5), rs2_n (5) and rd_n (5), all outputs, carrying the decoded fields of the head entry.
REQ-013 SHALL have ports PC_new (XLEN) and imm_n (XLEN), outputs, carrying the head PC and the sign-extended immediate.
REQ-014 SHALL have port count, output, width 3, the number of occupied entries (0 to DEPTH).

Function
REQ-015 SHALL decode fields as: opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
REQ-016 SHALL store the decoded fields, PC and immediate of each accepted instruction in a circular buffer of DEPTH entries with head and tail pointers that wrap at DEPTH.
REQ-017 SHALL drive in_ready = (count < DEPTH); there is no same-cycle bypass when full.
REQ-018 SHALL push an entry when in_valid & in_ready & !flush.
REQ-019 SHALL pop the head entry when out_valid & out_ready & !flush.
REQ-020 SHALL give a simultaneous push and pop in one cycle a net count change of 0, with both pointers advancing.
REQ-021 SHALL have a latency of exactly one cycle: an instruction accepted at edge N is visible on the outputs with out_valid=1 after edge N.
REQ-022 SHALL drive out_valid = (count != 0).
REQ-023 SHALL drive all field outputs, PC_new and imm_n to zero while out_valid=0 (bubble).
REQ-024 SHALL, when flush=1 at an edge, set count, head and tail to 0 and drop the input offered that cycle; flush takes priority over push and pop.
REQ-025 SHALL hold the head outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL generate immediates by opcode, sign-extended from instr[31]:
- I-type (0000011, 0010011, 1100111): instr[31:20]
- S-type (0100011): {instr[31:25], instr[11:7]}
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U-type (0110111, 0010111): {instr[31:12], 12'b0}
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- all other opcodes: 0

Reset
REQ-027 SHALL, on reset=1, immediately clear count, head, tail and all entry storage to 0, so that out_valid=0, all outputs are 0 and in_ready=1.
REQ-028 SHALL discard all buffered entries when reset is asserted mid-operation, with no partial pop.

Configuration
REQ-029 SHALL, when macro ID_EX_IMM_GEN_EN is defined, compute imm_n per REQ-026.
REQ-030 SHALL, when ID_EX_IMM_GEN_EN is undefined, omit the immediate generator and entry immediate storage and tie imm_n to zero; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover decode: after push of instr=0x00500113, PC_n=0x12 -> next cycle opcode_n=0010011, rd_n=2, rs1_n=0, funct3_n=000, imm_n=5, PC_new=0x12, out_valid=1.
REQ-032 SHALL cover back-to-back streaming: with out_ready=1, push 0x00500113, 0x00A00193, 0x00002223 on consecutive cycles -> outputs show rd=2/imm=5, then rd=3/imm=10, then opcode=0100011, funct3=010, imm=4, one per cycle, count stays 1.
REQ-033 SHALL cover backpressure: with out_ready=0 and DEPTH=2, push 3 instructions -> count=2, in_ready=0, third instruction is held upstream, head is unchanged; raise out_ready -> entries drain in order.
REQ-034 SHALL cover flush: with count=2 and flush=1 plus in_valid=1 -> next cycle count=0, out_valid=0, outputs are 0, the input is dropped.
REQ-035 SHALL cover async reset: assert reset mid-cycle with count=1 -> outputs are 0 and in_ready=1 before the next clk edge.
REQ-036 SHALL cover the macro: build without ID_EX_IMM_GEN_EN and push 0x00A00193 -> imm_n=0 while rd_n=3.

Source files
------------

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode/execute pipeline buffer. Decodes each accepted RV32 instruction
// into register fields plus PC. It holds up to DEPTH entries in a circular buffer
// with valid/ready handshakes on both sides.
// Optional build macro ID_EX_IMM_GEN_EN adds the immediate generator and per-entry
// immediate storage. When the macro is undefined, imm_n is tied to zero.
module id_ex_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] PC_n,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode_n,
  output logic [2:0]      funct3_n,
  output logic [6:0]      funct7_n,
  output logic [4:0]      rs1_n,
  output logic [4:0]      rs2_n,
  output logic [4:0]      rd_n,
  output logic [XLEN-1:0] PC_new,
  output logic [XLEN-1:0] imm_n,
  output logic [2:0]      count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
`ifdef ID_EX_IMM_GEN_EN
    logic [XLEN-1:0] imm;
`endif
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  entry_t             new_entry;
  entry_t             head_entry;

  // Advance a buffer pointer, wrapping at DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef ID_EX_IMM_GEN_EN
  // Opcode-selected immediate, built at 32 bits then sign-extended to XLEN.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i);
    logic [31:0] imm32;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm32 = {{20{i[31]}}, i[31:20]};
      7'b0100011:
        imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:
        imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {i[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    return XLEN'($signed(imm32));
  endfunction
`endif

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign head_entry = mem_q[head_q];

  // Field decode of the incoming instruction.
  always_comb begin
    new_entry        = '0;
    new_entry.opcode = instr[6:0];
    new_entry.rd     = instr[11:7];
    new_entry.funct3 = instr[14:12];
    new_entry.rs1    = instr[19:15];
    new_entry.rs2    = instr[24:20];
    new_entry.funct7 = instr[31:25];
    new_entry.pc     = PC_n;
`ifdef ID_EX_IMM_GEN_EN
    new_entry.imm    = gen_imm(instr);
`endif
  end

  // Buffer next state; flush overrides any push or pop.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = new_entry;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Head entry onto the outputs; zero bubble while empty.
  always_comb begin
    opcode_n = '0;
    funct3_n = '0;
    funct7_n = '0;
    rs1_n    = '0;
    rs2_n    = '0;
    rd_n     = '0;
    PC_new   = '0;
    imm_n    = '0;
    if (out_valid) begin
      opcode_n = head_entry.opcode;
      funct3_n = head_entry.funct3;
      funct7_n = head_entry.funct7;
      rs1_n    = head_entry.rs1;
      rs2_n    = head_entry.rs2;
      rd_n     = head_entry.rd;
      PC_new   = head_entry.pc;
`ifdef ID_EX_IMM_GEN_EN
      imm_n    = head_entry.imm;
`endif
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: scoreboard queue of expected head entries.
module tb_id_ex_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
`ifdef ID_EX_IMM_GEN_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] PC_n;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode_n;
  logic [2:0]      funct3_n;
  logic [6:0]      funct7_n;
  logic [4:0]      rs1_n;
  logic [4:0]      rs2_n;
  logic [4:0]      rd_n;
  logic [XLEN-1:0] PC_new;
  logic [XLEN-1:0] imm_n;
  logic [2:0]      count;

  id_ex_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .PC_n(PC_n), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode_n(opcode_n), .funct3_n(funct3_n),
    .funct7_n(funct7_n), .rs1_n(rs1_n), .rs2_n(rs2_n), .rd_n(rd_n),
    .PC_new(PC_new), .imm_n(imm_n), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: r = 32'($signed(i[31:20]));
      7'h23:               r = 32'($signed({i[31:25], i[11:7]}));
      7'h63:               r = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17:        r = {i[31:12], 12'h000};
      7'h6f:               r = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:             r = 32'h0;
    endcase
    return IMM_EN ? r : 32'h0;
  endfunction

  function automatic ent_t mk(input logic [31:0] i, input logic [31:0] pc);
    ent_t e;
    e.op = i[6:0];   e.rd = i[11:7];   e.f3 = i[14:12];
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f7 = i[31:25];
    e.pc = pc;       e.imm = ref_imm(i);
    return e;
  endfunction

  // Compare all outputs against the scoreboard head (zeros when empty).
  task automatic compare_all();
    ent_t e;
    e = '{default: '0};
    if (sb.size() != 0) e = sb[0];
    check("count",     64'(count),     64'(sb.size()));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready",  64'(in_ready),  64'(sb.size() < DEPTH));
    check("opcode",    64'(opcode_n),  64'(e.op));
    check("funct3",    64'(funct3_n),  64'(e.f3));
    check("funct7",    64'(funct7_n),  64'(e.f7));
    check("rs1",       64'(rs1_n),     64'(e.rs1));
    check("rs2",       64'(rs2_n),     64'(e.rs2));
    check("rd",        64'(rd_n),      64'(e.rd));
    check("pc",        64'(PC_new),    64'(e.pc));
    check("imm",       64'(imm_n),     64'(e.imm));
  endtask

  // One cycle: drive at negedge, compare before the edge, then update the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit do_push, do_pop;
    @(negedge clk);
    in_valid = v; instr = ins; PC_n = pc; out_ready = ordy; flush = fl;
    #1;
    compare_all();
    if (fl) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && ordy;
      do_push = v && (sb.size() < DEPTH);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(mk(ins, pc));
    end
  endtask

  localparam logic [31:0] I_ADDI2 = 32'h00500113;
  localparam logic [31:0] I_ADDI3 = 32'h00A00193;
  localparam logic [31:0] I_SW    = 32'h00002223;

  initial begin
    logic [31:0] rnd;
    logic [6:0]  ops [10];
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h0f};

    reset = 1'b1; in_valid = 1'b0; instr = '0; PC_n = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Decode of a single ADDI
    step(1'b1, I_ADDI2, 32'h12, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("d_opcode", 64'(opcode_n), 64'(7'b0010011));
    check("d_rd",     64'(rd_n),     64'd2);
    check("d_rs1",    64'(rs1_n),    64'd0);
    check("d_f3",     64'(funct3_n), 64'd0);
    check("d_imm",    64'(imm_n),    IMM_EN ? 64'd5 : 64'd0);
    check("d_pc",     64'(PC_new),   64'h12);
    check("d_valid",  64'(out_valid), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back streaming
    step(1'b1, I_ADDI2, 32'h100, 1'b1, 1'b0);
    step(1'b1, I_ADDI3, 32'h104, 1'b1, 1'b0);
    check("s0_rd",  64'(rd_n),  64'd2);
    check("s0_imm", 64'(imm_n), IMM_EN ? 64'd5 : 64'd0);
    step(1'b1, I_SW, 32'h108, 1'b1, 1'b0);
    check("s1_rd",  64'(rd_n),  64'd3);
    check("s1_imm", 64'(imm_n), IMM_EN ? 64'd10 : 64'd0);
    check("s1_cnt", 64'(count), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("s2_op",  64'(opcode_n), 64'(7'b0100011));
    check("s2_f3",  64'(funct3_n), 64'(3'b010));
    check("s2_imm", 64'(imm_n), IMM_EN ? 64'd4 : 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: third instruction held upstream, then drain in order
    step(1'b1, I_ADDI2, 32'h200, 1'b0, 1'b0);
    step(1'b1, I_ADDI3, 32'h204, 1'b0, 1'b0);
    step(1'b1, I_SW,    32'h208, 1'b0, 1'b0);
    check("bp_cnt",   64'(count),    64'd2);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_head",  64'(PC_new),   64'h200);
    step(1'b1, I_SW,    32'h208, 1'b1, 1'b0);
    step(1'b1, I_SW,    32'h208, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with two entries buffered and a live input
    step(1'b1, I_ADDI2, 32'h300, 1'b0, 1'b0);
    step(1'b1, I_ADDI3, 32'h304, 1'b0, 1'b0);
    step(1'b1, I_SW,    32'h308, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("fl_cnt",   64'(count),     64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_op",    64'(opcode_n),  64'd0);

    // Asynchronous reset mid-cycle with one entry buffered
    step(1'b1, I_ADDI3, 32'h400, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_ready", 64'(in_ready),  64'd1);
    check("ar_rd",    64'(rd_n),      64'd0);
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Macro-dependent immediate while fields still decode
    step(1'b1, I_ADDI3, 32'h500, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("m_rd",  64'(rd_n),  64'd3);
    check("m_imm", 64'(imm_n), IMM_EN ? 64'd10 : 64'd0);

    // Random traffic across all opcode classes
    for (int k = 0; k < 400; k++) begin
      rnd = $urandom;
      rnd[6:0] = ops[$urandom_range(0, 9)];
      step(1'($urandom_range(0, 3) != 0), rnd, $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
